ibex_efpga_ctrl: RTL and testbench

- Sequencing controller for the eFPGA custom-instruction (CX) unit in the EX stage.
- Accepts a CX request from ID and drives the operands and a start pulse to the fabric.
- Waits a programmable number of cycles, then captures the fabric result selected by the CX op type.
- Returns result and ready to the EX result mux and stall logic. Supplies the eFPGA result and ready signals to the EX block.

---
 rtl/ibex_efpga_ctrl_pkg.sv | 44 ++++
 rtl/ibex_efpga_delay_cnt.sv | 27 ++
 rtl/ibex_efpga_ctrl.sv | 149 ++++++++++++++
 tb/tb_ibex_efpga_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_efpga_ctrl_pkg.sv
// Shared types for the eFPGA custom-instruction controller: op types, FSM states,
// the latched request payload and the fabric result selector.
package ibex_efpga_ctrl_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned OpWidth   = 2;

    typedef enum logic [OpWidth-1:0] {
        CX_OP_A    = 2'b00,
        CX_OP_B    = 2'b01,
        CX_OP_C    = 2'b10,
        CX_OP_RSVD = 2'b11
    } cx_optype_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } efpga_ctrl_state_e;

    typedef struct packed {
        cx_optype_e           op;
        logic [DataWidth-1:0] operand_a;
        logic [DataWidth-1:0] operand_b;
    } cx_req_t;

    // Reserved op type yields zero; the caller raises the illegal flag separately.
    function automatic logic [DataWidth-1:0] cx_select(
        input cx_optype_e           op,
        input logic [DataWidth-1:0] res_a,
        input logic [DataWidth-1:0] res_b,
        input logic [DataWidth-1:0] res_c
    );
        logic [DataWidth-1:0] res;
        case (op)
            CX_OP_A: res = res_a;
            CX_OP_B: res = res_b;
            CX_OP_C: res = res_c;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ibex_efpga_delay_cnt.sv
// Loadable down-counter that saturates at zero; tracks remaining fabric latency.
module ibex_efpga_delay_cnt #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_c
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - Width'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/ibex_efpga_ctrl.sv
// Sequencer for the eFPGA custom-instruction unit in EX: issue, wait, capture, return.
// Optional performance counters are enabled with IBEX_EFPGA_PERF_CNT_EN.
module ibex_efpga_ctrl
    import ibex_efpga_ctrl_pkg::*;
#(
    parameter int unsigned DelayWidth   = 4,
    parameter int unsigned PerfCntWidth = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  kill_i,
    input  logic [OpWidth-1:0]    operator_i,
    input  logic [DelayWidth-1:0] delay_i,
    input  logic [DataWidth-1:0]  operand_a_i,
    input  logic [DataWidth-1:0]  operand_b_i,
    output logic [DataWidth-1:0]  efpga_operand_a_o,
    output logic [DataWidth-1:0]  efpga_operand_b_o,
    output logic [OpWidth-1:0]    efpga_op_o,
    output logic                  efpga_start_o,
    input  logic [DataWidth-1:0]  result_a_i,
    input  logic [DataWidth-1:0]  result_b_i,
    input  logic [DataWidth-1:0]  result_c_i,
    output logic                  ready_o,
    output logic [DataWidth-1:0]  endresult_o,
    output logic                  illegal_op_o
`ifdef IBEX_EFPGA_PERF_CNT_EN
    ,
    output logic [PerfCntWidth-1:0] cx_retired_o,
    output logic [PerfCntWidth-1:0] cx_stall_cycles_o
`endif
);

    efpga_ctrl_state_e    state_q, state_d;
    cx_req_t              req_q;
    logic                 start_q;
    logic [DataWidth-1:0] res_q;
    logic                 illegal_q;
    logic                 accept_c;
    logic                 capture_c;
    logic                 cnt_dec_c;
    logic                 cnt_zero_c;

    ibex_efpga_delay_cnt #(
        .Width (DelayWidth)
    ) u_delay_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept_c),
        .load_val_i (delay_i),
        .dec_i      (cnt_dec_c),
        .zero_c     (cnt_zero_c)
    );

    // Abort (kill or ID dropping the request) takes priority over capture in WAIT.
    always_comb begin
        state_d   = state_q;
        ready_o   = 1'b0;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        cnt_dec_c = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = !en_i;
                if (en_i && !kill_i) begin
                    accept_c = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (kill_i || !en_i) begin
                    state_d = IDLE;
                end else if (cnt_zero_c) begin
                    capture_c = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_dec_c = 1'b1;
                end
            end
            DONE: begin
                ready_o = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            start_q   <= 1'b0;
            res_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            start_q   <= accept_c;
            illegal_q <= capture_c && (req_q.op == CX_OP_RSVD);
            if (accept_c) begin
                req_q.op        <= cx_optype_e'(operator_i);
                req_q.operand_a <= operand_a_i;
                req_q.operand_b <= operand_b_i;
            end
            if (capture_c) begin
                res_q <= cx_select(req_q.op, result_a_i, result_b_i, result_c_i);
            end
        end
    end

    assign efpga_operand_a_o = req_q.operand_a;
    assign efpga_operand_b_o = req_q.operand_b;
    assign efpga_op_o        = req_q.op;
    assign efpga_start_o     = start_q;
    assign endresult_o       = res_q;
    // illegal_q is set only on the capture edge, so it is high exactly in DONE.
    assign illegal_op_o      = illegal_q;

`ifdef IBEX_EFPGA_PERF_CNT_EN
    logic [PerfCntWidth-1:0] retired_q;
    logic [PerfCntWidth-1:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (state_q == DONE) begin
                retired_q <= retired_q + PerfCntWidth'(1);
            end
            if (!ready_o && en_i) begin
                stall_q <= stall_q + PerfCntWidth'(1);
            end
        end
    end

    assign cx_retired_o      = retired_q;
    assign cx_stall_cycles_o = stall_q;
`else
    logic unused_perf_cnt_width;
    assign unused_perf_cnt_width = ^PerfCntWidth;
`endif

endmodule

// File: tb/tb_ibex_efpga_ctrl.sv
// Self-checking bench for ibex_efpga_ctrl: directed scenarios plus randomized ops
// checked against a cycle-indexed latency model of each CX request.
module tb_ibex_efpga_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i;
    logic        kill_i;
    logic [1:0]  operator_i;
    logic [3:0]  delay_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic [31:0] efpga_operand_a_o;
    logic [31:0] efpga_operand_b_o;
    logic [1:0]  efpga_op_o;
    logic        efpga_start_o;
    logic [31:0] result_a_i;
    logic [31:0] result_b_i;
    logic [31:0] result_c_i;
    logic        ready_o;
    logic [31:0] endresult_o;
    logic        illegal_op_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_res;

    always #5 clk = ~clk;

    ibex_efpga_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .en_i              (en_i),
        .kill_i            (kill_i),
        .operator_i        (operator_i),
        .delay_i           (delay_i),
        .operand_a_i       (operand_a_i),
        .operand_b_i       (operand_b_i),
        .efpga_operand_a_o (efpga_operand_a_o),
        .efpga_operand_b_o (efpga_operand_b_o),
        .efpga_op_o        (efpga_op_o),
        .efpga_start_o     (efpga_start_o),
        .result_a_i        (result_a_i),
        .result_b_i        (result_b_i),
        .result_c_i        (result_c_i),
        .ready_o           (ready_o),
        .endresult_o       (endresult_o),
        .illegal_op_o      (illegal_op_o)
    );

    function automatic logic [31:0] pick(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] c);
        if (op == 2'd0) return a;
        if (op == 2'd1) return b;
        if (op == 2'd2) return c;
        return 32'h0;
    endfunction

    // One request, cycle 0 = acceptance cycle. Normal: start at 1, ready at d+2.
    // abort_at>0: kill (or en drop) in that cycle, IDLE with no result next cycle.
    task automatic run_op(input logic [1:0] op, input int d, input int abort_at,
                          input bit by_kill, input bit kill_in_done,
                          input bit use_fix, input logic [31:0] fix_val);
        logic [31:0] a, b, new_res;
        int          last;
        bit          exp_ready, exp_start, exp_ill;
        a = $urandom; b = $urandom; new_res = 32'h0;
        en_i = 1'b1; kill_i = 1'b0; operator_i = op; delay_i = 4'(d);
        operand_a_i = a; operand_b_i = b;
        last = (abort_at > 0) ? abort_at + 1 : d + 2;
        for (int c = 0; c <= last; c++) begin
            result_a_i = use_fix ? fix_val : $urandom;
            result_b_i = use_fix ? fix_val : $urandom;
            result_c_i = use_fix ? fix_val : $urandom;
            if (c == d + 1) new_res = pick(op, result_a_i, result_b_i, result_c_i);
            if (c >= 1) begin
                operand_a_i = $urandom; operand_b_i = $urandom;
                operator_i = 2'($urandom); delay_i = 4'($urandom);
            end
            if (abort_at > 0 && c == abort_at) begin
                if (by_kill) kill_i = 1'b1; else en_i = 1'b0;
            end
            if (abort_at > 0 && c == abort_at + 1) begin
                kill_i = 1'b0; en_i = 1'b0;
            end
            if (abort_at == 0 && c == d + 2 && kill_in_done) kill_i = 1'b1;
            #1;
            exp_ready = (abort_at > 0) ? (c == abort_at + 1) : (c == d + 2);
            exp_start = (c == 1);
            exp_ill   = (abort_at == 0) && (c == d + 2) && (op == 2'd3);
            if (abort_at == 0 && c == d + 2) exp_res = new_res;
            checks++;
            if (ready_o !== exp_ready) begin
                errors++;
                $display("FAIL ready op=%0d d=%0d c=%0d got %b exp %b", op, d, c, ready_o, exp_ready);
            end
            checks++;
            if (efpga_start_o !== exp_start) begin
                errors++;
                $display("FAIL start op=%0d d=%0d c=%0d got %b exp %b", op, d, c, efpga_start_o, exp_start);
            end
            checks++;
            if (illegal_op_o !== exp_ill) begin
                errors++;
                $display("FAIL illegal op=%0d d=%0d c=%0d got %b exp %b", op, d, c, illegal_op_o, exp_ill);
            end
            checks++;
            if (endresult_o !== exp_res) begin
                errors++;
                $display("FAIL endresult op=%0d d=%0d c=%0d got %h exp %h", op, d, c, endresult_o, exp_res);
            end
            if (c == 1) begin
                checks++;
                if (efpga_operand_a_o !== a || efpga_operand_b_o !== b || efpga_op_o !== op) begin
                    errors++;
                    $display("FAIL operands got %h/%h/%0d exp %h/%h/%0d",
                             efpga_operand_a_o, efpga_operand_b_o, efpga_op_o, a, b, op);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        en_i = 1'b0; kill_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            checks++;
            if (ready_o !== 1'b1 || efpga_start_o !== 1'b0 || illegal_op_o !== 1'b0) begin
                errors++;
                $display("FAIL idle ctrl got ready=%b start=%b ill=%b exp 1/0/0",
                         ready_o, efpga_start_o, illegal_op_o);
            end
            checks++;
            if (endresult_o !== exp_res) begin
                errors++;
                $display("FAIL idle endresult got %h exp %h", endresult_o, exp_res);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en_i = 1'b0; kill_i = 1'b0; operator_i = 2'd0; delay_i = 4'd0;
        operand_a_i = 32'h0; operand_b_i = 32'h0;
        result_a_i = 32'h0; result_b_i = 32'h0; result_c_i = 32'h0;
        exp_res = 32'h0;
        #12;
        checks++;
        if (ready_o !== 1'b1 || efpga_start_o !== 1'b0 || illegal_op_o !== 1'b0 || endresult_o !== 32'h0) begin
            errors++;
            $display("FAIL reset got ready=%b start=%b ill=%b res=%h exp 1/0/0/0",
                     ready_o, efpga_start_o, illegal_op_o, endresult_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        run_op(2'd0, 3, 0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        idle(1);
        run_op(2'd2, 0, 0, 1'b0, 1'b0, 1'b1, 32'h12345678);
        idle(1);
        run_op(2'($urandom), 15, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(1);
    endtask

    task automatic test_back_to_back();
        run_op(2'd1, 1, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        run_op(2'd0, 2, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(2);
    endtask

    task automatic test_abort();
        run_op(2'd0, 5, 2, 1'b1, 1'b0, 1'b0, 32'h0);
        run_op(2'd1, 5, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(1);
        run_op(2'd2, 4, 3, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(1);
        run_op(2'd2, 2, 3, 1'b1, 1'b0, 1'b0, 32'h0);
        run_op(2'd0, 2, 0, 1'b0, 1'b1, 1'b0, 32'h0);
        idle(1);
    endtask

    task automatic test_kill_idle();
        en_i = 1'b1; kill_i = 1'b1; operator_i = 2'd0; delay_i = 4'd1;
        @(negedge clk);
        kill_i = 1'b0; en_i = 1'b0;
        #1;
        checks++;
        if (efpga_start_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL kill_idle got start=%b ready=%b exp 0/1", efpga_start_o, ready_o);
        end
        @(negedge clk);
        idle(1);
    endtask

    task automatic test_illegal();
        run_op(2'd3, 2, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(2);
    endtask

    task automatic test_reset_mid_wait();
        run_op(2'd1, 1, 0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001);
        en_i = 1'b1; kill_i = 1'b0; operator_i = 2'd2; delay_i = 4'd15;
        operand_a_i = 32'hFFFF_0000 | 32'($urandom_range(1, 255));
        operand_b_i = $urandom;
        for (int i = 0; i < 6; i++) @(negedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL midwait ready got %b exp 0", ready_o);
        end
        rst_n = 1'b0; en_i = 1'b0;
        exp_res = 32'h0;
        #1;
        checks++;
        if (ready_o !== 1'b1 || efpga_start_o !== 1'b0 || illegal_op_o !== 1'b0 || endresult_o !== 32'h0
            || efpga_operand_a_o !== 32'h0 || efpga_op_o !== 2'd0) begin
            errors++;
            $display("FAIL async_reset got ready=%b start=%b ill=%b res=%h a=%h op=%0d exp 1/0/0/0/0/0",
                     ready_o, efpga_start_o, illegal_op_o, endresult_o, efpga_operand_a_o, efpga_op_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [1:0] op;
            int         d, ab;
            op = 2'($urandom_range(0, 3));
            d  = $urandom_range(0, 15);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, d + 1) : 0;
            run_op(op, d, ab, 1'($urandom), ($urandom_range(0, 3) == 0), 1'b0, 32'h0);
            if (ab != 0 || $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort();
        test_kill_idle();
        test_illegal();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
